// File: rtl/coarse_cfo_autocorr.sv
// Streaming lag-DELAY autocorrelator for the STF: sliding sum over WIN_LEN
// products x[n]*conj(x[n-DELAY]), feeding the coarse-CFO angle stage.
module coarse_cfo_autocorr #(
  parameter int DATA_W  = 16,
  parameter int DELAY   = 16,
  parameter int WIN_LEN = 64,
  parameter int ACC_W   = 2*DATA_W + 1 + $clog2(WIN_LEN)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  acc_re,
  output logic signed [ACC_W-1:0]  acc_im
);

  localparam int PROD_W = 2*DATA_W + 1;
  localparam int FULL   = DELAY + WIN_LEN;
  localparam int FILL_W = $clog2(FULL + 1);
  localparam int DPTR_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int PPTR_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int PCNT_W = $clog2(WIN_LEN + 1);

  function automatic logic signed [PROD_W-1:0] sx_prod(input logic signed [DATA_W-1:0] v);
    return {{(PROD_W-DATA_W){v[DATA_W-1]}}, v};
  endfunction

  function automatic logic signed [ACC_W-1:0] sx_acc(input logic signed [PROD_W-1:0] v);
    return {{(ACC_W-PROD_W){v[PROD_W-1]}}, v};
  endfunction

  logic signed [DATA_W-1:0] xre_mem [DELAY];
  logic signed [DATA_W-1:0] xim_mem [DELAY];
  logic signed [PROD_W-1:0] pre_mem [WIN_LEN];
  logic signed [PROD_W-1:0] pim_mem [WIN_LEN];

  logic [DPTR_W-1:0]        dptr_q, dptr_d;
  logic [PPTR_W-1:0]        pptr_q, pptr_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
  logic                     v1_q, v1_d;
  logic                     full1_q, full1_d;
  logic signed [PROD_W-1:0] p_re_q, p_re_d;
  logic signed [PROD_W-1:0] p_im_q, p_im_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;
  logic                     ov_q, ov_d;

  logic                     en_s;
  logic                     accept_s;
  logic                     upd_s;
  logic signed [DATA_W-1:0] d_re_s, d_im_s;
  logic signed [PROD_W-1:0] old_re_s, old_im_s;

  assign en_s      = !ov_q || out_ready;
  assign in_ready  = en_s && !clear && !ap_rst;
  assign accept_s  = in_valid && in_ready;
  assign upd_s     = en_s && v1_q && !clear;
  assign out_valid = ov_q;
  assign acc_re    = acc_re_q;
  assign acc_im    = acc_im_q;

  // Masked delay-line reads: history older than the fill point reads as zero.
  always_comb begin
    d_re_s   = DATA_W'(0);
    d_im_s   = DATA_W'(0);
    old_re_s = PROD_W'(0);
    old_im_s = PROD_W'(0);
    if (fill_q >= FILL_W'(DELAY)) begin
      d_re_s = xre_mem[dptr_q];
      d_im_s = xim_mem[dptr_q];
    end else begin
      d_re_s = DATA_W'(0);
      d_im_s = DATA_W'(0);
    end
    if (pcnt_q == PCNT_W'(WIN_LEN)) begin
      old_re_s = pre_mem[pptr_q];
      old_im_s = pim_mem[pptr_q];
    end else begin
      old_re_s = PROD_W'(0);
      old_im_s = PROD_W'(0);
    end
  end

  // Next-state for both pipeline stages, fill tracking and frame restart.
  always_comb begin
    dptr_d   = dptr_q;
    pptr_d   = pptr_q;
    fill_d   = fill_q;
    pcnt_d   = pcnt_q;
    v1_d     = v1_q;
    full1_d  = full1_q;
    p_re_d   = p_re_q;
    p_im_d   = p_im_q;
    acc_re_d = acc_re_q;
    acc_im_d = acc_im_q;
    ov_d     = ov_q;
    if (clear) begin
      fill_d   = FILL_W'(0);
      pcnt_d   = PCNT_W'(0);
      v1_d     = 1'b0;
      acc_re_d = ACC_W'(0);
      acc_im_d = ACC_W'(0);
      ov_d     = 1'b0;
    end else begin
      if (en_s) begin
        v1_d = accept_s;
      end else begin
        v1_d = v1_q;
      end
      if (accept_s) begin
        p_re_d  = sx_prod(in_re) * sx_prod(d_re_s) + sx_prod(in_im) * sx_prod(d_im_s);
        p_im_d  = sx_prod(in_im) * sx_prod(d_re_s) - sx_prod(in_re) * sx_prod(d_im_s);
        full1_d = (fill_q >= FILL_W'(FULL - 1));
        fill_d  = (fill_q == FILL_W'(FULL)) ? fill_q : fill_q + FILL_W'(1);
        dptr_d  = (dptr_q == DPTR_W'(DELAY - 1)) ? DPTR_W'(0) : dptr_q + DPTR_W'(1);
      end else begin
        full1_d = full1_q;
      end
      // Window slides only when a product actually enters stage 2.
      if (upd_s) begin
        acc_re_d = acc_re_q + sx_acc(p_re_q) - sx_acc(old_re_s);
        acc_im_d = acc_im_q + sx_acc(p_im_q) - sx_acc(old_im_s);
        ov_d     = full1_q;
        pptr_d   = (pptr_q == PPTR_W'(WIN_LEN - 1)) ? PPTR_W'(0) : pptr_q + PPTR_W'(1);
        pcnt_d   = (pcnt_q == PCNT_W'(WIN_LEN)) ? pcnt_q : pcnt_q + PCNT_W'(1);
      end else if (en_s) begin
        ov_d = 1'b0;
      end else begin
        ov_d = ov_q;
      end
    end
  end

  // Pipeline and control state registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      dptr_q   <= DPTR_W'(0);
      pptr_q   <= PPTR_W'(0);
      fill_q   <= FILL_W'(0);
      pcnt_q   <= PCNT_W'(0);
      v1_q     <= 1'b0;
      full1_q  <= 1'b0;
      p_re_q   <= PROD_W'(0);
      p_im_q   <= PROD_W'(0);
      acc_re_q <= ACC_W'(0);
      acc_im_q <= ACC_W'(0);
      ov_q     <= 1'b0;
    end else begin
      dptr_q   <= dptr_d;
      pptr_q   <= pptr_d;
      fill_q   <= fill_d;
      pcnt_q   <= pcnt_d;
      v1_q     <= v1_d;
      full1_q  <= full1_d;
      p_re_q   <= p_re_d;
      p_im_q   <= p_im_d;
      acc_re_q <= acc_re_d;
      acc_im_q <= acc_im_d;
      ov_q     <= ov_d;
    end
  end

  // Delay-line storage; stale contents are hidden by the fill masks.
  always_ff @(posedge ap_clk) begin
    if (accept_s) begin
      xre_mem[dptr_q] <= in_re;
      xim_mem[dptr_q] <= in_im;
    end
    if (upd_s) begin
      pre_mem[pptr_q] <= p_re_q;
      pim_mem[pptr_q] <= p_im_q;
    end
  end

endmodule
